ram_access_unit: RTL and testbench

//   Sequential data-memory port between control/ALU and data RAM. Takes store data from the
//   ALU output router (RAM destination) and writes it to RAM. Fetches direct-addressing operands

---
 rtl/ram_access_unit.sv | 117 +++++++++++
 tb/tb_ram_access_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_unit.sv
// Sequential data-memory port: one load or store at a time over a req/ack handshake to the
// data RAM, with a bounded wait for mem_ack and a pipeline stall while the access is open.
module ram_access_unit #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_store,
   input  logic              req_load,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              ready,
   output logic              stall,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   load_data_q;
   logic                we_q;
   logic                load_q;
   logic [CNT_W-1:0]    count_q;
   logic                load_valid_q;
   logic                err_q;

   logic accept;
   logic illegal;
   logic in_access;
   logic at_limit;

   assign accept    = (state_q == StIdle) && req_valid && (req_load ^ req_store);
   assign illegal   = (state_q == StIdle) && req_valid && req_load && req_store;
   assign in_access = (state_q == StAccess);
   assign at_limit  = (count_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StAccess;
         StAccess: if (mem_ack || at_limit) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         load_data_q  <= '0;
         we_q         <= 1'b0;
         load_q       <= 1'b0;
         count_q      <= '0;
         load_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         err_q        <= illegal;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= store_data;
            we_q    <= req_store;
            load_q  <= req_load;
            count_q <= '0;
         end
         // An ack on the final allowed cycle still completes the access normally.
         if (in_access) begin
            if (mem_ack) begin
               if (load_q) begin
                  load_data_q  <= mem_rdata;
                  load_valid_q <= 1'b1;
               end
            end else if (at_limit) begin
               err_q <= 1'b1;
            end else begin
               count_q <= count_q + CNT_W'(1);
            end
         end
      end
   end

   assign ready      = (state_q == StIdle);
   assign stall      = (state_q != StIdle);
   assign mem_req    = in_access;
   assign mem_we     = in_access && we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ram_access_unit.sv
// Directed bench for ram_access_unit: load/store handshakes, timeout, illegal and
// overlapping requests, and asynchronous reset during an access.
module tb_ram_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_store, req_load;
   logic [7:0]  req_addr;
   logic [31:0] store_data;
   logic        ready, stall, load_valid, err;
   logic [31:0] load_data;
   logic        mem_req, mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ack;

   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;
   int req_cnt = 0;

   ram_access_unit #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_store  (req_store),
      .req_load   (req_load),
      .req_addr   (req_addr),
      .store_data (store_data),
      .ready      (ready),
      .stall      (stall),
      .load_data  (load_data),
      .load_valid (load_valid),
      .err        (err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (stall === 1'b1) stall_cnt++;
      if (mem_req === 1'b1) req_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic st, input logic [7:0] a, input logic [31:0] d);
      req_valid  = 1'b1;
      req_load   = ld;
      req_store  = st;
      req_addr   = a;
      store_data = d;
   endtask

   task automatic drop_req();
      req_valid = 1'b0;
      req_load  = 1'b0;
      req_store = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_store = 1'b0; req_load = 1'b0;
      req_addr = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
      #12;
      chk("rst_ready", ready, 1);
      chk("rst_stall", stall, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_load_data", load_data, 0);
      chk("rst_load_valid", load_valid, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      tick();

      // Load from 0x10, ack one cycle after mem_req rises.
      stall_cnt = 0;
      issue(1'b1, 1'b0, 8'h10, 32'h0);
      tick();
      drop_req();
      chk("ld_mem_req", mem_req, 1);
      chk("ld_mem_we", mem_we, 0);
      chk("ld_mem_addr", mem_addr, 8'h10);
      chk("ld_ready", ready, 0);
      tick();
      chk("ld_mem_req_hold", mem_req, 1);
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      chk("ld_valid", load_valid, 1);
      chk("ld_data", load_data, 32'hDEADBEEF);
      chk("ld_done_req", mem_req, 0);
      tick();
      chk("ld_valid_pulse", load_valid, 0);
      chk("ld_ready_back", ready, 1);
      chk("ld_stall_cycles", stall_cnt, 3);

      // Store 0x12345678 to 0x22, ack after 4 cycles.
      issue(1'b0, 1'b1, 8'h22, 32'h12345678);
      tick();
      drop_req();
      store_data = 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) begin
         chk("st_mem_req", mem_req, 1);
         chk("st_mem_we", mem_we, 1);
         chk("st_mem_addr", mem_addr, 8'h22);
         chk("st_mem_wdata", mem_wdata, 32'h12345678);
         if (i < 3) tick();
      end
      mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
      tick();
      mem_ack = 1'b0;
      chk("st_no_valid", load_valid, 0);
      chk("st_no_err", err, 0);
      chk("st_load_data", load_data, 32'hDEADBEEF);
      tick();
      chk("st_ready_back", ready, 1);

      // Load with no ack: timeout after 15 ACCESS cycles.
      req_cnt = 0;
      issue(1'b1, 1'b0, 8'h30, 32'h0);
      tick();
      drop_req();
      repeat (15) tick();
      chk("to_err", err, 1);
      chk("to_no_valid", load_valid, 0);
      chk("to_req_cycles", req_cnt, 15);
      chk("to_load_data", load_data, 32'hDEADBEEF);
      tick();
      chk("to_err_pulse", err, 0);
      chk("to_ready_back", ready, 1);

      // Ack on the 15th ACCESS cycle wins over the timeout.
      issue(1'b1, 1'b0, 8'h40, 32'h0);
      tick();
      drop_req();
      repeat (14) tick();
      chk("late_req_still", mem_req, 1);
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ack = 1'b0;
      chk("late_valid", load_valid, 1);
      chk("late_no_err", err, 0);
      chk("late_data", load_data, 32'hCAFEF00D);
      tick();
      chk("late_ready_back", ready, 1);

      // Both flags set: err pulse, no access.
      req_cnt = 0;
      issue(1'b1, 1'b1, 8'h44, 32'h5);
      tick();
      drop_req();
      chk("ill_err", err, 1);
      chk("ill_ready", ready, 1);
      tick();
      chk("ill_err_pulse", err, 0);
      chk("ill_no_req", req_cnt, 0);

      // A request presented mid-ACCESS is ignored.
      issue(1'b1, 1'b0, 8'h50, 32'h0);
      tick();
      issue(1'b0, 1'b1, 8'h60, 32'hAAAA5555);
      tick();
      chk("busy_addr", mem_addr, 8'h50);
      chk("busy_we", mem_we, 0);
      mem_ack = 1'b1; mem_rdata = 32'h11112222;
      drop_req();
      tick();
      mem_ack = 1'b0;
      chk("busy_valid", load_valid, 1);
      chk("busy_data", load_data, 32'h11112222);
      tick();
      tick();
      chk("busy_idle_req", mem_req, 0);
      chk("busy_req_cycles", req_cnt, 2);

      // Async reset mid-ACCESS, then a stray ack while idle.
      issue(1'b1, 1'b0, 8'h70, 32'h0);
      tick();
      drop_req();
      tick();
      rst_n = 1'b0;
      #1;
      chk("ar_mem_req", mem_req, 0);
      chk("ar_ready", ready, 1);
      chk("ar_stall", stall, 0);
      chk("ar_load_data", load_data, 0);
      chk("ar_mem_addr", mem_addr, 0);
      tick();
      rst_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h99999999;
      tick();
      mem_ack = 1'b0;
      chk("ar_no_valid", load_valid, 0);
      chk("ar_no_err", err, 0);
      tick();
      chk("ar_no_valid2", load_valid, 0);
      chk("ar_no_err2", err, 0);
      chk("ar_ack_ignored", load_data, 0);
      chk("ar_idle", ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
